// File: rtl/lsu_seq.sv
// lsu_seq: sequential load/store unit with func3 legality and alignment checks.
// Define LSU_MISALIGN_EN to split misaligned half/word accesses into byte cycles.
module lsu_seq #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_func3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

`ifdef LSU_MISALIGN_EN
  typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_e;
`else
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
`endif

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          func3_q, func3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                legal;
  logic                misaligned;

`ifdef LSU_MISALIGN_EN
  logic [1:0]          k_q, k_d;
  logic [31:0]         asm_q, asm_d;
  logic [31:0]         asm_full;
  logic [31:0]         asm_ext;
  logic                split_last;

  // Assembly register with the byte arriving this cycle already merged in.
  always_comb begin
    asm_full = asm_q;
    asm_full[{k_q, 3'b000} +: 8] = mem_rdata[7:0];
    case (func3_q)
      3'b001:  asm_ext = {{16{asm_full[15]}}, asm_full[15:0]};
      3'b101:  asm_ext = {16'h0000, asm_full[15:0]};
      default: asm_ext = asm_full;
    endcase
    split_last = (func3_q[1:0] == 2'b01) ? (k_q == 2'd1) : (k_q == 2'd3);
  end
`endif

  always_comb begin
    case (req_func3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !req_we;
      default:                legal = 1'b0;
    endcase
    misaligned = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    func3_d    = func3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_func3  = 3'b000;
    mem_addr   = '0;
    mem_wdata  = 32'h0;
`ifdef LSU_MISALIGN_EN
    k_d        = k_q;
    asm_d      = asm_q;
`endif
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          func3_d = req_func3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = 1'b0;
          if (!legal) begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
            state_d = RESP;
          end else if (misaligned) begin
`ifdef LSU_MISALIGN_EN
            k_d     = 2'd0;
            asm_d   = 32'h0;
            state_d = SPLIT;
`else
            err_d   = 1'b1;
            rdata_d = 32'h0;
            state_d = RESP;
`endif
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        mem_read  = !we_q;
        mem_write = we_q;
        mem_func3 = func3_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        rdata_d   = we_q ? 32'h0 : mem_rdata;
        state_d   = RESP;
      end
`ifdef LSU_MISALIGN_EN
      SPLIT: begin
        mem_read  = !we_q;
        mem_write = we_q;
        mem_func3 = we_q ? 3'b000 : 3'b100;
        mem_addr  = addr_q + ADDR_W'(k_q);
        mem_wdata = wdata_q >> {k_q, 3'b000};
        asm_d     = asm_full;
        k_d       = k_q + 2'd1;
        if (split_last) begin
          rdata_d = we_q ? 32'h0 : asm_ext;
          k_d     = 2'd0;
          state_d = RESP;
        end
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      func3_q <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
`ifdef LSU_MISALIGN_EN
      k_q     <= 2'd0;
      asm_q   <= 32'h0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      func3_q <= func3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef LSU_MISALIGN_EN
      k_q     <= k_d;
      asm_q   <= asm_d;
`endif
    end
  end

  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_seq.sv
// tb_lsu_seq: randomized and directed checks of lsu_seq against a byte-level
// behavioural model with its own shadow memory.
module tb_lsu_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_func3 = 3'b000;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_func3;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

`ifdef LSU_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  lsu_seq #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_func3(mem_func3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment memory driven by the DUT's strobes.
  logic [7:0] env_mem [256];
  logic [7:0] rb0, rb1, rb2, rb3;
  always_comb begin
    rb0 = env_mem[mem_addr];
    rb1 = env_mem[mem_addr + 8'd1];
    rb2 = env_mem[mem_addr + 8'd2];
    rb3 = env_mem[mem_addr + 8'd3];
    mem_rdata = 32'h0;
    if (mem_read) begin
      case (mem_func3)
        3'b000:  mem_rdata = {{24{rb0[7]}}, rb0};
        3'b001:  mem_rdata = {{16{rb1[7]}}, rb1, rb0};
        3'b010:  mem_rdata = {rb3, rb2, rb1, rb0};
        3'b100:  mem_rdata = {24'h0, rb0};
        3'b101:  mem_rdata = {16'h0, rb1, rb0};
        default: mem_rdata = 32'h0;
      endcase
    end
  end
  always @(posedge clk) begin
    if (mem_write) begin
      env_mem[mem_addr] <= mem_wdata[7:0];
      if (mem_func3[1:0] != 2'b00) env_mem[mem_addr + 8'd1] <= mem_wdata[15:8];
      if (mem_func3[1:0] == 2'b10) begin
        env_mem[mem_addr + 8'd2] <= mem_wdata[23:16];
        env_mem[mem_addr + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  // Model: shadow memory plus a queue of expected per-cycle outputs.
  typedef struct packed {
    logic        rdy;
    logic        rv;
    logic        err;
    logic [31:0] rdata;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [7:0]  a;
    logic [31:0] wd;
  } cyc_t;

  logic [7:0]  ref_mem [256];
  cyc_t        expq [$];
  logic [31:0] mdl_rdata = 32'h0;
  bit          chk_en = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          obs_cyc, obs_lat, obs_rd, obs_wr;
  logic [31:0] obs_rdata;
  logic        obs_err;
  cyc_t        cmp_e;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic plan(input logic we, input logic [2:0] f3, input logic [7:0] a,
                      input logic [31:0] wd, output int lat);
    cyc_t        c;
    int          sz;
    logic        legal, mis;
    logic [31:0] val;
    sz    = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis   = (int'(a) % sz) != 0;
    c       = '0;
    c.rdata = mdl_rdata;
    if (!legal || (mis && !MIS_EN)) begin
      c.rv = 1'b1; c.err = 1'b1; c.rdata = 32'h0;
      expq.push_back(c);
      mdl_rdata = 32'h0;
      lat = 1;
      return;
    end
    val = 32'h0;
    for (int i = 0; i < sz; i++) begin
      if (we) ref_mem[8'(int'(a) + i)] = wd[8*i +: 8];
      else    val[8*i +: 8] = ref_mem[8'(int'(a) + i)];
    end
    if (!we && !f3[2] && sz == 1) val = {{24{val[7]}}, val[7:0]};
    if (!we && !f3[2] && sz == 2) val = {{16{val[15]}}, val[15:0]};
    c.rd = !we;
    c.wr = we;
    if (!mis) begin
      c.f3 = f3; c.a = a; c.wd = wd;
      expq.push_back(c);
      lat = 2;
    end else begin
      for (int i = 0; i < sz; i++) begin
        c.f3 = we ? 3'b000 : 3'b100;
        c.a  = 8'(int'(a) + i);
        c.wd = wd >> (8 * i);
        expq.push_back(c);
      end
      lat = sz + 1;
    end
    c = '0;
    c.rv    = 1'b1;
    c.rdata = we ? 32'h0 : val;
    expq.push_back(c);
    mdl_rdata = c.rdata;
  endtask

  // Every cycle: pop the expected outputs (or the idle expectation) and compare.
  always @(negedge clk) begin
    if (chk_en) begin
      if (expq.size() > 0) begin
        cmp_e = expq.pop_front();
      end else begin
        cmp_e       = '0;
        cmp_e.rdy   = 1'b1;
        cmp_e.rdata = mdl_rdata;
      end
      obs_cyc++;
      chk("req_ready",  32'(req_ready),  32'(cmp_e.rdy));
      chk("resp_valid", 32'(resp_valid), 32'(cmp_e.rv));
      chk("resp_err",   32'(resp_err),   32'(cmp_e.err));
      chk("resp_rdata", resp_rdata,      cmp_e.rdata);
      chk("mem_read",   32'(mem_read),   32'(cmp_e.rd));
      chk("mem_write",  32'(mem_write),  32'(cmp_e.wr));
      chk("mem_func3",  32'(mem_func3),  32'(cmp_e.f3));
      chk("mem_addr",   32'(mem_addr),   32'(cmp_e.a));
      chk("mem_wdata",  mem_wdata,       cmp_e.wd);
      if (resp_valid) begin
        obs_rdata = resp_rdata;
        obs_err   = resp_err;
        obs_lat   = obs_cyc;
      end
      if (mem_read)  obs_rd++;
      if (mem_write) obs_wr++;
    end
  end

  int txn = 0;

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [7:0] a, input logic [31:0] wd);
    int t;
    int lat;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 at %0t", $time);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    plan(we, f3, a, wd, lat);
    obs_cyc = 0; obs_lat = -1; obs_rd = 0; obs_wr = 0;
    obs_rdata = 32'hX; obs_err = 1'bX;
    // Keep valid high with junk while busy: the unit must ignore it.
    req_we = 1'($urandom); req_func3 = 3'($urandom); req_addr = 8'($urandom); req_wdata = $urandom;
    repeat (lat) @(negedge clk);
    #1;
    req_valid = 1'b0;
    txn++;
    $display("txn %0d we=%0b f3=%03b addr=%02h wdata=%08h -> rdata=%08h err=%0b lat=%0d rd=%0d wr=%0d",
             txn, we, f3, a, wd, obs_rdata, obs_err, obs_lat, obs_rd, obs_wr);
  endtask

  task automatic lit(input string nm, input logic [31:0] r, input logic e, input int lat,
                     input int nrd, input int nwr);
    chk({nm, " rdata"}, obs_rdata, r);
    chk({nm, " err"}, 32'(obs_err), 32'(e));
    chk({nm, " latency"}, 32'(obs_lat), 32'(lat));
    chk({nm, " reads"}, 32'(obs_rd), 32'(nrd));
    chk({nm, " writes"}, 32'(obs_wr), 32'(nwr));
  endtask

`ifdef LSU_MISALIGN_EN
  task automatic abort_test();
    logic rv_seen;
    chk_en = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b010; req_addr = 8'h21; req_wdata = 32'h55667788;
    @(negedge clk);
    chk("abort ready before", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rv_seen = resp_valid;
    chk("abort cycle1 write addr", {23'h0, mem_write, mem_addr}, 32'h121);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    rv_seen |= resp_valid;
    chk("abort cycle2 write addr", {23'h0, mem_write, mem_addr}, 32'h122);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      rv_seen |= resp_valid;
      chk("abort idle ready", 32'(req_ready), 32'd1);
      chk("abort idle write", 32'(mem_write), 32'd0);
      chk("abort idle rdata", resp_rdata, 32'h0);
    end
    chk("abort no resp_valid", 32'(rv_seen), 32'd0);
    chk("abort byte 0x21", 32'(env_mem[8'h21]), 32'h88);
    chk("abort byte 0x22", 32'(env_mem[8'h22]), 32'h77);
    chk("abort byte 0x23", 32'(env_mem[8'h23]), 32'hAD);
    chk("abort byte 0x24", 32'(env_mem[8'h24]), 32'hDE);
    ref_mem[8'h21] = 8'h88;
    ref_mem[8'h22] = 8'h77;
    mdl_rdata = 32'h0;
    @(posedge clk); #1;
    chk_en = 1'b1;
  endtask
`endif

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [7:0]  a;
    logic [31:0] wd;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] <= 8'h00;
      ref_mem[i] = 8'h00;
    end
    env_mem[0] <= 8'd17; env_mem[4] <= 8'd9; env_mem[8] <= 8'd25;
    ref_mem[0] = 8'd17;  ref_mem[4] = 8'd9;  ref_mem[8] = 8'd25;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'h0);
    chk("reset resp_err", 32'(resp_err), 32'd0);
    chk("reset mem strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("reset mem_addr", 32'(mem_addr), 32'h0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    do_req(1'b0, 3'b010, 8'h00, 32'h0); lit("lw 0x00", 32'h00000011, 1'b0, 2, 1, 0);
    do_req(1'b0, 3'b011, 8'h10, 32'h0); lit("load f3=011", 32'h0, 1'b1, 1, 0, 0);
    do_req(1'b1, 3'b100, 8'h10, 32'h12345678); lit("store f3=100", 32'h0, 1'b1, 1, 0, 0);
    do_req(1'b1, 3'b010, 8'h40, 32'hCAFEF00D); lit("sw 0x40", 32'h0, 1'b0, 2, 0, 1);
    do_req(1'b0, 3'b001, 8'h42, 32'h0); lit("lh 0x42", 32'hFFFFCAFE, 1'b0, 2, 1, 0);
    do_req(1'b0, 3'b101, 8'h42, 32'h0); lit("lhu 0x42", 32'h0000CAFE, 1'b0, 2, 1, 0);
    do_req(1'b0, 3'b000, 8'h40, 32'h0); lit("lb 0x40", 32'h0000000D, 1'b0, 2, 1, 0);
`ifdef LSU_MISALIGN_EN
    do_req(1'b0, 3'b010, 8'h01, 32'h0); lit("lw 0x01", 32'h09000000, 1'b0, 5, 4, 0);
    do_req(1'b0, 3'b001, 8'h03, 32'h0); lit("lh 0x03", 32'h00000900, 1'b0, 3, 2, 0);
    do_req(1'b1, 3'b010, 8'h21, 32'hDEADBEEF); lit("sw 0x21", 32'h0, 1'b0, 5, 0, 4);
    do_req(1'b0, 3'b010, 8'h21, 32'h0); lit("lw 0x21", 32'hDEADBEEF, 1'b0, 5, 4, 0);
    do_req(1'b0, 3'b000, 8'h21, 32'h0); lit("lb 0x21", 32'hFFFFFFEF, 1'b0, 2, 1, 0);
    do_req(1'b0, 3'b100, 8'h21, 32'h0); lit("lbu 0x21", 32'h000000EF, 1'b0, 2, 1, 0);
    do_req(1'b1, 3'b010, 8'hFE, 32'h11223344); lit("sw 0xFE", 32'h0, 1'b0, 5, 0, 4);
    do_req(1'b0, 3'b010, 8'hFE, 32'h0); lit("lw 0xFE", 32'h11223344, 1'b0, 5, 4, 0);
    abort_test();
`else
    do_req(1'b0, 3'b010, 8'h02, 32'h0); lit("lw 0x02 misaligned", 32'h0, 1'b1, 1, 0, 0);
    do_req(1'b1, 3'b001, 8'h41, 32'hFFFF); lit("sh 0x41 misaligned", 32'h0, 1'b1, 1, 0, 0);
`endif

    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 8'(8'hFC + $urandom_range(0, 3)) : 8'($urandom);
      wd = we ? $urandom : 32'h0;
      do_req(we, f3, a, wd);
    end

    repeat (3) @(posedge clk);
    chk("queue drained", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_seq.md
# lsu_seq

Sequential load/store unit between the execute stage and the byte-addressed data memory. Takes one load/store request per valid/ready handshake and checks func3 legality and alignment. It drives the data memory port for one cycle (aligned) or a sequence of byte cycles (misaligned, split). It returns the assembled, sign- or zero-extended load data or a store completion as a one-cycle response pulse.

## Interface
Parameters:
- ADDR_W, 8, byte-address width of data memory; all address arithmetic is modulo 2^ADDR_W.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_func3  in  3  RV32I load/store funct3.
- req_addr  in  ADDR_W  byte address from ALU.
- req_wdata  in  32  store data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid: illegal func3 or disallowed misalignment.
- mem_read  out  1  data memory read enable.
- mem_write  out  1  data memory write enable; memory commits on the clk edge ending the cycle.
- mem_func3  out  3  width code to memory.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; combinational from mem_addr/mem_func3/mem_read.

## Operation
- Legal loads use func3 000 (lb), 001 (lh), 010 (lw), 100 (lbu) and 101 (lhu). Legal stores use func3 000 (sb), 001 (sh) and 010 (sw). All other codes are illegal and produce an error response with no memory access.
- Alignment rules: a word is aligned when addr[1:0]==0. A half is aligned when addr[0]==0. Bytes are always aligned.
- States are IDLE, ACCESS, SPLIT, RESP.
- IDLE: req_ready=1. On req_valid, latch the request and go:
  - to RESP with err when the request is illegal;
  - to ACCESS when aligned;
  - to SPLIT when misaligned, with byte count N = 2 (half) or 4 (word).
- ACCESS: one cycle. Drives mem_* with the latched func3, addr and wdata. For loads, mem_rdata is captured into resp_rdata. Go to RESP.
- SPLIT: counter k runs 0..N-1, one byte per cycle at mem_addr = addr+k (wrapping).
  - Stores: func3 000 with mem_wdata = wdata >> (8k).
  - Loads: func3 100; byte k is captured into bits [8k+7:8k] of an assembly register.
  - After k=N-1, extend the result per the original func3 (lh sign-extends bit 15, lhu zero-extends) and go to RESP.
- RESP: resp_valid=1 for one cycle, then IDLE.
- mem_read and mem_write are 0 outside ACCESS/SPLIT. mem_addr, mem_func3 and mem_wdata are 0 in IDLE/RESP.
- resp_rdata holds its value until the next response.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, all mem_*=0; state IDLE, k=0.
- Let the accept edge be cycle 0. Latencies to resp_valid:
  - aligned: ACCESS in cycle 1, RESP in cycle 2;
  - misaligned half: cycle 3;
  - misaligned word: cycle 5;
  - error: cycle 1.
- Throughput: the next request is accepted in the cycle after RESP.
- req_valid while not ready is ignored; the requester holds it.
- Wrap-around: a word at address 0xFE covers bytes 0xFE, 0xFF, 0x00, 0x01.
- rst_n low during ACCESS/SPLIT aborts to IDLE on that edge. Byte writes already committed stay in memory, and no response is issued.

## Configuration
- LSU_MISALIGN_EN defined: misaligned half/word accesses are split as above.
- LSU_MISALIGN_EN undefined: misaligned accesses take the error path (resp_err=1 in cycle 1, no memory strobe), and the SPLIT state and counter are not built.

## Test plan
- Memory words 0,4,8 = 17, 9, 25. Issue lw at 0x00 → resp_valid in cycle 2, rdata=0x00000011, err=0, exactly one mem_read cycle.
- With LSU_MISALIGN_EN, issue lw at 0x01 → four byte reads at 0x01..0x04, rdata=0x09000000 in cycle 5. lh at 0x03 → rdata=0x00000900 in cycle 3.
- With LSU_MISALIGN_EN, issue sw 0xDEADBEEF at 0x21 → four mem_write cycles with bytes EF, BE, AD, DE. Then lw 0x21 → 0xDEADBEEF; lb 0x21 → 0xFFFFFFEF; lbu 0x21 → 0x000000EF.
- Issue load with func3=011, or store with func3=100 → resp_err=1 in cycle 1, rdata=0, mem_read and mem_write never asserted. Without LSU_MISALIGN_EN, lw at 0x02 gives the same error response.
- With LSU_MISALIGN_EN, issue sw 0x11223344 at 0xFE → writes to 0xFE, 0xFF, 0x00, 0x01; lw 0xFE → 0x11223344.
- Drive rst_n low in cycle 2 of a misaligned sw at 0x21 → bytes 0x21 and 0x22 written, 0x23 and 0x24 untouched, no resp_valid, req_ready=1 after reset.
